timer_dev: RTL

Memory-mapped countdown timer. It is the responder on the CPU data bus for the window 0x7f00–0x7f0b, whose accesses the address-exception checker has already validated. The system bridge gates `we` and routes `addr` and `wdata` here; the block returns `rdata` combinationally and raises `irq` to CP0 on HWInt[2]. All accepted accesses are aligned, full-word accesses; byte and half accesses and writes to COUNT are filtered upstream.

---
 rtl/timer_dev.sv | 85 ++++++++
 1 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers at addr[3:2],
// one-shot or auto-reload countdown, interrupt request to CP0.
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t      st;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        pending;

  logic [1:0]  sel;
  logic        wr_ctrl, wr_preset, mode1, fire;
  logic        unused_addr;

  assign sel         = addr[3:2];
  assign unused_addr = ^{addr[31:4], addr[1:0]};
  assign wr_ctrl     = we && (sel == 2'b00);
  assign wr_preset   = we && (sel == 2'b01);
  assign mode1       = (ctrl[2:1] == 2'b01);
  assign fire        = (st == S_CNT) && ctrl[0] && (count <= 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= S_IDLE;
      ctrl    <= 4'd0;
      preset  <= PRESET_RST;
      count   <= 32'd0;
      pending <= 1'b0;
    end else begin
      if (wr_ctrl)   ctrl   <= wdata[3:0];
      if (wr_preset) preset <= wdata;
      // entering INT outranks the software clear
      if (fire)                        pending <= 1'b1;
      else if (wr_ctrl || wr_preset)   pending <= 1'b0;

      case (st)
        S_IDLE: if (ctrl[0]) st <= S_LOAD;
        S_LOAD: begin
          count <= preset;
          st    <= S_CNT;
        end
        S_CNT: begin
          if (!ctrl[0])
            st <= S_IDLE;
          else if (count <= 32'd1) begin
            count <= 32'd0;
            st    <= S_INT;
          end else
            count <= count - 32'd1;
        end
        S_INT: begin
          // auto-reload folds the idle pass into the reload: period is N+2
          st <= (mode1 && ctrl[0]) ? S_LOAD : S_IDLE;
          if (!mode1 && !wr_ctrl) ctrl[0] <= 1'b0;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (sel)
      2'b00:   rdata = {28'd0, ctrl};
      2'b01:   rdata = preset;
      2'b10:   rdata = count;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = ctrl[3] & (mode1 ? (st == S_INT) : pending);

endmodule
